// File: rtl/mc_proc_pkg.sv
// mc_proc_pkg: shared states, op1 classes and select encodings for the multi-cycle controller
package mc_proc_pkg;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;
  localparam logic [3:0] OP_ALU_R = 4'b0000;
  localparam logic [3:0] OP_CMP_R = 4'b0010;
  localparam logic [3:0] OP_ALU_I = 4'b1000;
  localparam logic [3:0] OP_CMP_I = 4'b1010;
  localparam logic [3:0] OP_LW    = 4'b1001;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BR    = 4'b0110;
  localparam logic [3:0] OP_JAL   = 4'b1011;
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_BR    = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;
  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;
  localparam logic [3:0] OP2_SUB_DEF = 4'b0001;
endpackage

// File: rtl/mc_proc_decode.sv
// mc_proc_decode: combinational op1/op2 decode into legality and execute mux controls
module mc_proc_decode
  import mc_proc_pkg::*;
#(
  parameter int                    OP_BIT_WIDTH = 4,
  parameter logic [OP_BIT_WIDTH-1:0] OP2_SUB    = OP2_SUB_DEF
) (
  input  logic [OP_BIT_WIDTH-1:0] op1,
  input  logic [OP_BIT_WIDTH-1:0] op2,
  output logic                    legal,
  output logic                    use_imm,
  output logic                    use_zero,
  output logic                    is_mvhi,
  output logic                    is_br_or_cond,
  output logic [OP_BIT_WIDTH-1:0] op_alu,
  output logic [OP_BIT_WIDTH-1:0] op_cond
);
  // branches and compares force a subtract so the condition unit sees op1-op2
  always_comb begin
    legal         = op1 inside {OP_ALU_R, OP_CMP_R, OP_ALU_I, OP_CMP_I, OP_LW, OP_SW, OP_BR, OP_JAL};
    is_mvhi       = op1 == OP_ALU_I && op2[1:0] == 2'b11;
    use_zero      = (op1 == OP_BR && op2[2]) || is_mvhi;
    use_imm       = op1[3];
    is_br_or_cond = op1[1] & ~op1[0];
    op_alu        = is_br_or_cond ? OP2_SUB : op2;
    op_cond       = op2;
  end
endmodule

// File: rtl/mc_proc_controller.sv
// mc_proc_controller: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; MC_PROC_CTRL_PERF_EN adds cycle/retire counters
module mc_proc_controller
  import mc_proc_pkg::*;
#(
  parameter int                      OP_BIT_WIDTH = 4,
`ifdef MC_PROC_CTRL_PERF_EN
  parameter int                      DBITS        = 32,
`endif
  parameter logic [OP_BIT_WIDTH-1:0] OP2_SUB      = OP2_SUB_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [OP_BIT_WIDTH-1:0] op1,
  input  logic [OP_BIT_WIDTH-1:0] op2,
  input  logic                    cond_out,
  input  logic                    imem_ack,
  input  logic                    dmem_ack,
  output logic                    imem_req,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic                    ir_we,
  output logic                    pc_we,
  output logic [1:0]              pc_sel,
  output logic                    reg_we,
  output logic [1:0]              wb_sel,
  output logic                    use_imm,
  output logic                    use_zero,
  output logic                    is_mvhi,
  output logic                    is_br_or_cond,
  output logic [OP_BIT_WIDTH-1:0] op_alu,
  output logic [OP_BIT_WIDTH-1:0] op_cond,
  output logic                    halted,
  output logic [2:0]              state
`ifdef MC_PROC_CTRL_PERF_EN
  ,
  output logic [DBITS-1:0]        cyc_cnt,
  output logic [DBITS-1:0]        instret_cnt
`endif
);
  state_e                  state_q, state_d;
  logic                    pend_q, pend_d;
  logic [OP_BIT_WIDTH-1:0] op1_q, op1_v, op2_q, op2_v;
  logic                    legal, live;
  logic                    d_imm, d_zero, d_mvhi, d_brc;
  logic [OP_BIT_WIDTH-1:0] d_alu, d_cond;
  // IR fields are captured in DECODE so execute controls stay frozen through WB
  always_comb begin
    op1_v = state_q == S_DECODE ? op1 : op1_q;
    op2_v = state_q == S_DECODE ? op2 : op2_q;
    live  = state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB};
  end
  mc_proc_decode #(.OP_BIT_WIDTH(OP_BIT_WIDTH), .OP2_SUB(OP2_SUB)) u_dec (
    .op1(op1_v), .op2(op2_v), .legal(legal), .use_imm(d_imm), .use_zero(d_zero),
    .is_mvhi(d_mvhi), .is_br_or_cond(d_brc), .op_alu(d_alu), .op_cond(d_cond)
  );
  // execute controls are only visible while an instruction is in flight
  always_comb begin
    use_imm       = live & d_imm;
    use_zero      = live & d_zero;
    is_mvhi       = live & d_mvhi;
    is_br_or_cond = live & d_brc;
    op_alu        = live ? d_alu : '0;
    op_cond       = live ? d_cond : '0;
    halted        = state_q == S_HALT;
    state         = state_q;
  end
  // next state and state-qualified single-cycle strobes; pend_q keeps a fetch alive if en drops
  always_comb begin
    state_d  = state_q;
    pend_d   = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    reg_we   = 1'b0;
    wb_sel   = WB_ALU;
    case (state_q)
      S_FETCH: begin
        imem_req = en | pend_q;
        pend_d   = imem_req & ~imem_ack;
        ir_we    = imem_req & imem_ack;
        pc_we    = ir_we;
        state_d  = ir_we ? S_DECODE : S_FETCH;
      end
      S_DECODE: state_d = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (op1_v == OP_LW || op1_v == OP_SW) state_d = S_MEM;
        else if (op1_v == OP_BR) begin
          pc_we   = cond_out;
          pc_sel  = cond_out ? PC_BR : PC_PLUS4;
          state_d = S_FETCH;
        end else if (op1_v == OP_JAL) begin
          pc_we   = 1'b1;
          pc_sel  = PC_ALU;
          reg_we  = 1'b1;
          wb_sel  = WB_PC4;
          state_d = S_FETCH;
        end else state_d = S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = op1_v == OP_SW;
        state_d  = !dmem_ack ? S_MEM : (op1_v == OP_SW ? S_FETCH : S_WB);
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = op1_v == OP_LW ? WB_MEM : WB_ALU;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end
`ifdef MC_PROC_CTRL_PERF_EN
  logic [DBITS-1:0] cyc_q, cyc_d, inst_q, inst_d;
  // cycles count outside HALT; retirement is any return to FETCH from EXEC/MEM/WB
  always_comb begin
    cyc_d       = cyc_q + DBITS'(state_q != S_HALT);
    inst_d      = inst_q + DBITS'(state_d == S_FETCH && state_q inside {S_EXEC, S_MEM, S_WB});
    cyc_cnt     = cyc_q;
    instret_cnt = inst_q;
  end
`endif
  // controller state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pend_q  <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
`ifdef MC_PROC_CTRL_PERF_EN
      cyc_q   <= '0;
      inst_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      op1_q   <= op1_v;
      op2_q   <= op2_v;
`ifdef MC_PROC_CTRL_PERF_EN
      cyc_q   <= cyc_d;
      inst_q  <= inst_d;
`endif
    end
  end
endmodule

// File: tb/tb_mc_proc_controller.sv
// tb_mc_proc_controller: directed cycle-by-cycle checks of the multi-cycle controller
module tb_mc_proc_controller;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, cond_out = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [3:0] op1 = '0, op2 = '0;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, use_imm, use_zero, is_mvhi, is_br_or_cond, halted;
  logic [1:0] pc_sel, wb_sel;
  logic [3:0] op_alu, op_cond;
  logic [2:0] state;
  logic [10:0] strb;
  logic [11:0] ex;
  int errs = 0, checks = 0;
`ifdef MC_PROC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, instret_cnt;
`endif
  mc_proc_controller dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op1(op1), .op2(op2), .cond_out(cond_out),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .wb_sel(wb_sel), .use_imm(use_imm), .use_zero(use_zero), .is_mvhi(is_mvhi),
    .is_br_or_cond(is_br_or_cond), .op_alu(op_alu), .op_cond(op_cond), .halted(halted),
    .state(state)
`ifdef MC_PROC_CTRL_PERF_EN
    , .cyc_cnt(cyc_cnt), .instret_cnt(instret_cnt)
`endif
  );
  always #5 clk = ~clk;
  assign strb = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel, halted};
  assign ex   = {use_imm, use_zero, is_mvhi, is_br_or_cond, op_alu, op_cond};
  function automatic logic [10:0] s(input logic ir, dr, dw, iw, pw, input logic [1:0] ps,
                                    input logic rw, input logic [1:0] ws, input logic h);
    return {ir, dr, dw, iw, pw, ps, rw, ws, h};
  endfunction
  localparam logic [10:0] FS = 11'b10011000000;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic [2:0] st, input logic [10:0] sb);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".strobes"}, 32'(strb), 32'(sb));
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input string tag, input logic [3:0] o1, input logic [3:0] o2);
    op1 = o1;
    op2 = o2;
    en = 1'b1;
    imem_ack = 1'b1;
    step(tag, 3'd0, FS);
    en = 1'b0;
    imem_ack = 1'b0;
  endtask
  initial begin
    #12;
    chk("reset.state", 32'(state), 0);
    chk("reset.strobes", 32'(strb), 0);
    chk("reset.ex", 32'(ex), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fetch("alu.f", 4'b0000, 4'b0011);
    #1 chk("alu.ex", 32'(ex), 32'h033);
    step("alu.d", 3'd1, 0);
    step("alu.e", 3'd2, 0);
    step("alu.w", 3'd4, s(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0));
    fetch("lw.f", 4'b1001, 4'b0000);
    #1 chk("lw.ex", 32'(ex), 32'h800);
    step("lw.d", 3'd1, 0);
    step("lw.e", 3'd2, 0);
    for (int i = 0; i < 3; i++) step("lw.wait", 3'd3, s(0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0));
    dmem_ack = 1'b1;
    step("lw.ack", 3'd3, s(0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 0));
    dmem_ack = 1'b0;
    step("lw.w", 3'd4, s(0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 0));
    fetch("brt.f", 4'b0110, 4'b0100);
    #1 chk("brt.ex", 32'(ex), 32'h514);
    step("brt.d", 3'd1, 0);
    cond_out = 1'b1;
    step("brt.e", 3'd2, s(0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 0));
    cond_out = 1'b0;
    fetch("brn.f", 4'b0110, 4'b0000);
    #1 chk("brn.ex", 32'(ex), 32'h110);
    step("brn.d", 3'd1, 0);
    step("brn.e", 3'd2, 0);
    fetch("jal.f", 4'b1011, 4'b0010);
    #1 chk("jal.ex", 32'(ex), 32'h822);
    step("jal.d", 3'd1, 0);
    step("jal.e", 3'd2, s(0, 0, 0, 0, 1, 2'd2, 1, 2'd2, 0));
    fetch("mvhi.f", 4'b1000, 4'b0011);
    #1 chk("mvhi.ex", 32'(ex), 32'he33);
    step("mvhi.d", 3'd1, 0);
    step("mvhi.e", 3'd2, 0);
    step("mvhi.w", 3'd4, s(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0));
    fetch("cmpi.f", 4'b1010, 4'b0111);
    #1 chk("cmpi.ex", 32'(ex), 32'h917);
    step("cmpi.d", 3'd1, 0);
    step("cmpi.e", 3'd2, 0);
    step("cmpi.w", 3'd4, s(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0));
    for (int i = 0; i < 5; i++) begin
      imem_ack = i[0];
      step("idle", 3'd0, 0);
    end
    op1 = 4'b0000;
    op2 = 4'b0000;
    en = 1'b1;
    imem_ack = 1'b0;
    step("hold0", 3'd0, s(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0));
    en = 1'b0;
    step("hold1", 3'd0, s(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0));
    imem_ack = 1'b1;
    step("hold2", 3'd0, FS);
    imem_ack = 1'b0;
    step("hold.d", 3'd1, 0);
    step("hold.e", 3'd2, 0);
    step("hold.w", 3'd4, s(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0));
    fetch("sw.f", 4'b0101, 4'b0110);
    #1 chk("sw.ex", 32'(ex), 32'h066);
    step("sw.d", 3'd1, 0);
    step("sw.e", 3'd2, 0);
    #1 chk("sw.mem", 32'(strb), 32'(s(0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 0)));
    rst_n = 1'b0;
    #1;
    chk("sw.rst.dmem_req", 32'(dmem_req), 0);
    chk("sw.rst.state", 32'(state), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("sw.after", 3'd0, 0);
    fetch("ill.f", 4'b1111, 4'b0000);
    step("ill.d", 3'd1, 0);
    for (int i = 0; i < 4; i++) begin
      en = 1'b1;
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      step("halt", 3'd5, s(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 1));
    end
    en = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("halt.rst.halted", 32'(halted), 0);
    chk("halt.rst.state", 32'(state), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`ifdef MC_PROC_CTRL_PERF_EN
    for (int i = 0; i < 10; i++) begin
      fetch("perf.f", 4'b0000, 4'b0001);
      step("perf.d", 3'd1, 0);
      step("perf.e", 3'd2, 0);
      step("perf.w", 3'd4, s(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 0));
    end
    chk("perf.instret", instret_cnt, 32'd10);
    chk("perf.cyc", cyc_cnt, 32'd40);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
